// File: rtl/regfile_pkg.sv
// Shared constants for the FlexiCore multi-port register file.
// FSM state encodings and the index of the externally mapped entry.
package regfile_pkg;

    localparam logic [1:0] RF_IDLE  = 2'd0;
    localparam logic [1:0] RF_CLEAR = 2'd1;

    localparam int RF_EXT_IDX = 1;

endpackage

// File: rtl/regfile_addr_decoder.sv
// Binary-to-one-hot decoder with an enable.
// When en is low the output is all zeros.
module addr_decoder #(
    parameter int AW = 3
) (
    input  logic                 en,
    input  logic [AW-1:0]        addr,
    output logic [(1<<AW)-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: 2 read ports, 1 write port, entry 0 exported, entry 1 external.
// Build option: define REGFILE_RDREG_EN for registered (1-cycle, write-first) read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WEN,
    input  logic [AW-1:0]    WADDR,
    input  logic [WIDTH-1:0] WDATA,
    input  logic [AW-1:0]    RADDR_A,
    output logic [WIDTH-1:0] RDATA_A,
    input  logic [AW-1:0]    RADDR_B,
    output logic [WIDTH-1:0] RDATA_B,
    output logic [WIDTH-1:0] RF0DATA,
    input  logic [WIDTH-1:0] RF1DATA,
    input  logic             CLR_REQ,
    output logic             CLR_BUSY,
    output logic [1:0]       DBG_STATE
);

    localparam logic [AW-1:0] EXT_ADDR  = AW'(RF_EXT_IDX);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    // Entry 1 has no storage, so slot k holds entry k+1 for k>=1.
    logic [WIDTH-1:0] mem [DEPTH-1];

    logic [1:0]       state;
    logic [AW-1:0]    clr_cnt;
    logic             clr_busy;
    logic             clearing;
    logic             wr_fire;
    logic [DEPTH-1:0] wr_oh;
    logic [DEPTH-1:0] clr_oh;
    logic [WIDTH-1:0] rd_a_comb;
    logic [WIDTH-1:0] rd_b_comb;

    function automatic logic [AW-1:0] slot_of(input logic [AW-1:0] idx);
        return (idx == '0) ? '0 : idx - 1'b1;
    endfunction

    assign clearing = (state == RF_CLEAR);
    assign wr_fire  = WEN && !clr_busy && (WADDR != EXT_ADDR);

    addr_decoder #(.AW(AW)) u_wr_dec (
        .en     (wr_fire),
        .addr   (WADDR),
        .onehot (wr_oh)
    );

    addr_decoder #(.AW(AW)) u_clr_dec (
        .en     (clearing),
        .addr   (clr_cnt),
        .onehot (clr_oh)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= RF_IDLE;
            clr_cnt  <= '0;
            clr_busy <= 1'b0;
        end else begin
            case (state)
                RF_IDLE: begin
                    if (CLR_REQ) begin
                        state    <= RF_CLEAR;
                        clr_cnt  <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                RF_CLEAR: begin
                    // Requests arriving here are dropped; the sweep always runs to the end.
                    if (clr_cnt == LAST_ADDR) begin
                        state    <= RF_IDLE;
                        clr_cnt  <= '0;
                        clr_busy <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= RF_IDLE;
                    clr_cnt  <= '0;
                    clr_busy <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem[i[AW-1:0]] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (clr_oh[i]) begin
                    if (i != RF_EXT_IDX) begin
                        mem[slot_of(AW'(i))] <= '0;
                    end
                end else if (wr_oh[i]) begin
                    if (i != RF_EXT_IDX) begin
                        mem[slot_of(AW'(i))] <= WDATA;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_a_comb = (RADDR_A == EXT_ADDR) ? RF1DATA : mem[slot_of(RADDR_A)];
        rd_b_comb = (RADDR_B == EXT_ADDR) ? RF1DATA : mem[slot_of(RADDR_B)];
    end

`ifdef REGFILE_RDREG_EN
    logic [WIDTH-1:0] rdata_a_q;
    logic [WIDTH-1:0] rdata_b_q;

    // Write-first: a same-edge write to the addressed entry bypasses storage.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            rdata_a_q <= (wr_fire && (WADDR == RADDR_A)) ? WDATA : rd_a_comb;
            rdata_b_q <= (wr_fire && (WADDR == RADDR_B)) ? WDATA : rd_b_comb;
        end
    end

    assign RDATA_A = rdata_a_q;
    assign RDATA_B = rdata_b_q;
`else
    assign RDATA_A = rd_a_comb;
    assign RDATA_B = rd_b_comb;
`endif

    assign RF0DATA   = mem[0];
    assign CLR_BUSY  = clr_busy;
    assign DBG_STATE = state;

endmodule
